bist_scan_ctrl: RTL and testbench

Parametrised on-chip logic-BIST controller for the multi-chain scan versions of the s9234 core. It generalises the fixed 7-bit LFSR pattern generator in two ways: it adds a shift/capture sequencing state machine, and it adds a MISR compactor with pass/fail evaluation against a golden signature. It drives SI_chain and scan_en into the scan-inserted core and compacts SO_chain, so a full self-test runs with no external pattern data.

---
 rtl/bist_scan_ctrl_if.sv | 32 +++
 rtl/bist_scan_ctrl.sv | 110 +++++++++++
 tb/tb_bist_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bist_scan_ctrl_if.sv
// Scan-side signal bundle between the logic-BIST controller and its environment.
// The controller sits on the slave modport; the environment that starts runs and returns scan-outs is the master.
interface bist_scan_ctrl_if #(
    parameter int NUM_CHAINS = 7,
    parameter int MISR_W     = 16,
    parameter int CNT_W      = 10
);
    logic                  bist_start;
    logic [NUM_CHAINS-1:0] SO_chain;
    logic [NUM_CHAINS-1:0] SI_chain;
    logic                  scan_en;
    logic                  bist_busy;
    logic                  bist_done;
    logic                  bist_pass;
    logic [MISR_W-1:0]     misr_sig;
    logic [CNT_W-1:0]      pattern_cnt;
    logic [1:0]            state_dbg;

    // Start is a one-cycle request with no acknowledge: it is acted on only
    // when the controller is in IDLE or DONE, and silently dropped otherwise.
    modport master (
        output bist_start, SO_chain,
        input  SI_chain, scan_en, bist_busy, bist_done, bist_pass,
        input  misr_sig, pattern_cnt, state_dbg
    );

    modport slave (
        input  bist_start, SO_chain,
        output SI_chain, scan_en, bist_busy, bist_done, bist_pass,
        output misr_sig, pattern_cnt, state_dbg
    );
endinterface

// File: rtl/bist_scan_ctrl.sv
// Logic-BIST controller: LFSR pattern source, shift/capture sequencer and MISR
// compactor with a pass/fail verdict against a golden signature.
module bist_scan_ctrl #(
    parameter int                NUM_CHAINS   = 7,
    parameter int                CHAIN_LEN    = 33,
    parameter int                NUM_PATTERNS = 1000,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'h0001,
    parameter int                MISR_W       = 16,
    parameter logic [MISR_W-1:0] MISR_POLY    = 16'hB400,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = 16'h0000
) (
    input logic              CK,
    input logic              BIST_reset,
    bist_scan_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
    localparam int SC_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    if (LFSR_SEED == '0) begin : g_seed_chk
        $error("bist_scan_ctrl: LFSR_SEED must be non-zero");
    end
    if (NUM_CHAINS < 1 || NUM_CHAINS > LFSR_W || NUM_CHAINS > MISR_W) begin : g_chain_chk
        $error("bist_scan_ctrl: NUM_CHAINS out of range");
    end
    if (CHAIN_LEN < 1 || NUM_PATTERNS < 1) begin : g_len_chk
        $error("bist_scan_ctrl: CHAIN_LEN and NUM_PATTERNS must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_next;
    logic [MISR_W-1:0] misr_q, misr_d, misr_next;
    logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0]  pattern_cnt_q, pattern_cnt_d;

    always_ff @(posedge CK) begin
        if (BIST_reset) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            misr_q        <= '0;
            shift_cnt_q   <= '0;
            pattern_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            misr_q        <= misr_d;
            shift_cnt_q   <= shift_cnt_d;
            pattern_cnt_q <= pattern_cnt_d;
        end
    end

    always_comb begin
        lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
        misr_next = (misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0) ^ MISR_W'(bus.SO_chain);
    end

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        misr_d        = misr_q;
        shift_cnt_d   = shift_cnt_q;
        pattern_cnt_d = pattern_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.bist_start) begin
                    state_d       = S_SHIFT;
                    lfsr_d        = LFSR_SEED;
                    misr_d        = '0;
                    shift_cnt_d   = '0;
                    pattern_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                lfsr_d = lfsr_next;
                // The first load shifts out power-on garbage, so it is not compacted.
                if (pattern_cnt_q != '0) begin
                    misr_d = misr_next;
                end
                if (shift_cnt_q == SC_W'(CHAIN_LEN - 1)) begin
                    shift_cnt_d = '0;
                    state_d     = (pattern_cnt_q == CNT_W'(NUM_PATTERNS)) ? S_DONE : S_CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            S_CAPTURE: begin
                pattern_cnt_d = pattern_cnt_q + CNT_W'(1);
                state_d       = S_SHIFT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.SI_chain    = lfsr_q[NUM_CHAINS-1:0];
    assign bus.scan_en     = (state_q == S_SHIFT);
    assign bus.bist_busy   = (state_q == S_SHIFT) || (state_q == S_CAPTURE);
    assign bus.bist_done   = (state_q == S_DONE);
    assign bus.bist_pass   = (state_q == S_DONE) && (misr_q == GOLDEN_SIG);
    assign bus.misr_sig    = misr_q;
    assign bus.pattern_cnt = pattern_cnt_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_bist_scan_ctrl.sv
// Directed bench for bist_scan_ctrl with 2 chains of length 4 and 3 patterns:
// per-cycle sequencing, LFSR/MISR values, pass/fail, mid-run reset and restart.
module tb_bist_scan_ctrl;
    localparam int          NC     = 2;
    localparam int          CL     = 4;
    localparam int          NP     = 3;
    localparam int          CW     = 2;
    localparam logic [15:0] POLY   = 16'hB400;
    localparam logic [15:0] GOLDEN = 16'h0000;

    logic CK;
    logic BIST_reset;
    int   checks;
    int   errors;

    logic [15:0] m_lfsr;
    logic [15:0] m_misr;
    logic [15:0] last_sig;
    // Expected scan_en for run cycles 1..19: four shifts, one capture, repeated.
    logic [18:0] se_tab;

    bist_scan_ctrl_if #(.NUM_CHAINS(NC), .MISR_W(16), .CNT_W(CW)) bus ();

    bist_scan_ctrl #(
        .NUM_CHAINS  (NC),
        .CHAIN_LEN   (CL),
        .NUM_PATTERNS(NP)
    ) dut (
        .CK        (CK),
        .BIST_reset(BIST_reset),
        .bus       (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_scan_en"}, 32'(bus.scan_en), 32'd0);
        chk({nm, "_busy"},    32'(bus.bist_busy), 32'd0);
        chk({nm, "_done"},    32'(bus.bist_done), 32'd0);
        chk({nm, "_pass"},    32'(bus.bist_pass), 32'd0);
        chk({nm, "_si"},      32'(bus.SI_chain), 32'h1);
        chk({nm, "_misr"},    32'(bus.misr_sig), 32'h0);
        chk({nm, "_pcnt"},    32'(bus.pattern_cnt), 32'h0);
    endtask

    // One BIST run with SO_chain held at so. abort_at > 0 pulses reset on that
    // cycle (with a start request); noisy adds stray starts in SHIFT and CAPTURE.
    task automatic run(input logic [1:0] so, input int abort_at, input bit noisy, input string nm);
        int pc;
        bit se;
        m_lfsr = 16'h0001;
        m_misr = 16'h0000;
        bus.SO_chain   = so;
        bus.bist_start = 1'b1;
        tick();
        bus.bist_start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            se = se_tab[k-1];
            pc = (k - 1) / 5;
            chk({nm, "_busy"},    32'(bus.bist_busy), 32'd1);
            chk({nm, "_done"},    32'(bus.bist_done), 32'd0);
            chk({nm, "_scan_en"}, 32'(bus.scan_en), 32'(se));
            chk({nm, "_pcnt"},    32'(bus.pattern_cnt), 32'(pc));
            chk({nm, "_si"},      32'(bus.SI_chain), 32'(m_lfsr[1:0]));
            chk({nm, "_misr"},    32'(bus.misr_sig), 32'(m_misr));
            if (k <= 3) chk({nm, "_si_hand"}, 32'(bus.SI_chain), (k == 1) ? 32'h1 : 32'h0);
            if (k <= 5) chk({nm, "_misr_load"}, 32'(bus.misr_sig), 32'h0);
            if (k == abort_at) begin
                BIST_reset     = 1'b1;
                bus.bist_start = 1'b1;
            end else begin
                bus.bist_start = noisy && (k == 2 || k == 5);
            end
            tick();
            BIST_reset     = 1'b0;
            bus.bist_start = 1'b0;
            if (k == abort_at) begin
                chk_reset({nm, "_rst"});
                tick();
                chk_reset({nm, "_idle"});
                return;
            end
            if (se) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? POLY : 16'h0);
            if (se && pc > 0) m_misr = {1'b0, m_misr[15:1]} ^ (m_misr[0] ? POLY : 16'h0) ^ {14'h0, so};
        end
        chk({nm, "_end_done"},    32'(bus.bist_done), 32'd1);
        chk({nm, "_end_busy"},    32'(bus.bist_busy), 32'd0);
        chk({nm, "_end_scan_en"}, 32'(bus.scan_en), 32'd0);
        chk({nm, "_end_pcnt"},    32'(bus.pattern_cnt), 32'd3);
        chk({nm, "_end_misr"},    32'(bus.misr_sig), 32'(m_misr));
        chk({nm, "_end_pass"},    32'(bus.bist_pass), 32'(m_misr == GOLDEN));
        tick();
        chk({nm, "_hold_done"},   32'(bus.bist_done), 32'd1);
        chk({nm, "_hold_misr"},   32'(bus.misr_sig), 32'(m_misr));
        chk({nm, "_hold_si"},     32'(bus.SI_chain), 32'(m_lfsr[1:0]));
        last_sig = m_misr;
    endtask

    initial begin
        logic [15:0] sig_first;
        checks         = 0;
        errors         = 0;
        se_tab         = 19'b1111_0_1111_0_1111_0_1111;
        BIST_reset     = 1'b1;
        bus.bist_start = 1'b0;
        bus.SO_chain   = 2'b00;
        tick();
        tick();
        chk_reset("reset");

        // Start while reset is held must be overridden.
        bus.bist_start = 1'b1;
        tick();
        bus.bist_start = 1'b0;
        BIST_reset     = 1'b0;
        chk_reset("reset_start");
        tick();
        chk_reset("idle");

        // All-zero scan-outs: signature stays 0 and matches the golden value.
        run(2'b00, 0, 1'b0, "zero");
        chk("zero_pass_hand", 32'(bus.bist_pass), 32'd1);
        chk("zero_sig_hand",  32'(bus.misr_sig), 32'h0);

        // Chain 0 stuck at 1, restarted from DONE, with stray start pulses.
        run(2'b01, 0, 1'b1, "so0");
        sig_first = last_sig;
        chk("so0_sig_nonzero", 32'(bus.misr_sig != 16'h0), 32'd1);
        chk("so0_fail",        32'(bus.bist_pass), 32'd0);

        // Identical restart must reproduce the same signature.
        run(2'b01, 0, 1'b0, "restart");
        chk("restart_same_sig", 32'(bus.misr_sig), 32'(sig_first));
        chk("restart_fail",     32'(bus.bist_pass), 32'd0);

        // Reset during the second pattern's shift, then a clean run.
        run(2'b01, 7, 1'b0, "abort");
        run(2'b00, 0, 1'b0, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
